// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, FSM state encoding and an odd-parity helper.
// Used by both the receive and transmit sides of the PS/2 port.
package ps2_pkg;

  // Frame layout: start bit, data bits LSB first, odd parity, stop bit.
  localparam int unsigned PS2_DATA_BITS = 8;
  localparam logic        PS2_START_BIT = 1'b0;
  localparam logic        PS2_STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StData   = 3'd1,
    StParity = 3'd2,
    StStop   = 3'd3,
    StDone   = 3'd4
  } ps2_state_e;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 input conditioning: 2-flop synchronizers on ps2c/ps2d, a FILTER_LEN-cycle glitch
// filter on the clock line and a one-cycle pulse on each filtered falling edge.
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2c_f,
  output logic fall_tick,
  output logic ps2d_s
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]      c_sync_q;
  logic [1:0]      d_sync_q;
  logic            c_f_q, c_f_d;
  logic            c_f_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            c_s;

  assign c_s = c_sync_q[1];

  // Synchronizers; idle-high so reset looks like a quiet bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
    end
  end

  // Glitch filter: follow the synced clock only after it disagrees for FILTER_LEN cycles.
  always_comb begin
    c_f_d = c_f_q;
    cnt_d = '0;
    if (c_s != c_f_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        c_f_d = c_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_f_q     <= 1'b1;
      c_f_dly_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      c_f_q     <= c_f_d;
      c_f_dly_q <= c_f_q;
      cnt_q     <= cnt_d;
    end
  end

  assign ps2c_f    = c_f_q;
  assign fall_tick = c_f_dly_q & ~c_f_q;
  assign ps2d_s    = d_sync_q[1];

endmodule

// File: rtl/ps2_receive.sv
// PS/2 device-to-host receiver. Deframes start/8 data/odd parity/stop frames sampled on
// filtered ps2c falling edges and presents one byte per good frame. Never drives the bus.
// Optional mid-frame watchdog is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       rx_idle
);

  logic       ps2c_f;
  logic       fall_tick;
  logic       ps2d_s;

  ps2_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       parity_q, parity_d;
  logic       frame_ok;
  logic       timeout;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .ps2c_f   (ps2c_f),
    .fall_tick(fall_tick),
    .ps2d_s   (ps2d_s)
  );

  // Evaluated in the stop-bit tick cycle: stop bit must be 1 and parity odd.
  assign frame_ok = (ps2d_s == PS2_STOP_BIT) && odd_parity_ok(shreg_q, parity_q);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             busy;

  assign busy    = (state_q == StData) || (state_q == StParity) || (state_q == StStop);
  // Fires on the cycle the count would reach TIMEOUT_CYCLES without an intervening tick.
  assign timeout = busy && !fall_tick && (wdog_q == WdogW'(TIMEOUT_CYCLES - 1));

  // Watchdog next value: counts only between ticks while a frame is in flight.
  always_comb begin
    wdog_d = '0;
    if (busy && !fall_tick && !timeout) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
    end
  end

  // Next-state and datapath update; rx_en low or a watchdog expiry forces IDLE.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    if (!rx_en || timeout) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (fall_tick && (ps2d_s == PS2_START_BIT)) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          if (fall_tick) begin
            shreg_d   = {ps2d_s, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
              state_d = StParity;
            end
          end
        end
        StParity: begin
          if (fall_tick) begin
            parity_d = ps2d_s;
            state_d  = StStop;
          end
        end
        StStop: begin
          if (fall_tick) begin
            if (frame_ok) begin
              // Load now so rx_data is already valid while rx_done is high.
              rx_data_d = shreg_q;
              state_d   = StDone;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output decode: done/err pulses and idle flag.
  always_comb begin
    rx_done = (state_q == StDone);
    rx_err  = 1'b0;
    if (rx_en) begin
      if (timeout) begin
        rx_err = 1'b1;
      end else if ((state_q == StStop) && fall_tick && !frame_ok) begin
        rx_err = 1'b1;
      end
    end
    rx_idle = (state_q == StIdle);
  end

  assign rx_data = rx_data_q;

  // Filtered clock level is not needed by the deframer; only its falling edge is.
  logic unused_ps2c_f;
  assign unused_ps2c_f = ps2c_f;

endmodule

// File: tb/tb_ps2_receive.sv
// Directed bench for ps2_receive: a device model drives PS/2 frames bit by bit and each
// scenario task checks pulse counts, captured bytes and idle state against hand values.
module tb_ps2_receive;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 500;
  localparam int          HALF = 40;
  localparam int          QTR  = 20;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c  = 1'b1;
  logic       ps2d  = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;
  logic       rx_idle;

  int vectors     = 0;
  int miscompares = 0;

  int         done_cnt    = 0;
  int         err_cnt     = 0;
  int         overlap_cnt = 0;
  int         wide_cnt    = 0;
  logic       done_prev   = 1'b0;
  logic       err_prev    = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  ps2_receive #(
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .rx_en  (rx_en),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .rx_err (rx_err),
    .rx_idle(rx_idle)
  );

  // Pulse monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      got_q.push_back(rx_data);
    end
    if (rx_err) err_cnt++;
    if (rx_done && rx_err) overlap_cnt++;
    if ((rx_done && done_prev) || (rx_err && err_prev)) wide_cnt++;
    done_prev = rx_done;
    err_prev  = rx_err;
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    repeat (QTR) @(posedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2c = 1'b1;
    repeat (QTR) @(posedge clk);
  endtask

  // frame[0] is the start bit, sent first.
  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) send_bit(frame[i]);
    ps2d = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par,
                                           input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    settle(4);
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", rx_data); end
    vectors++; if (rx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", rx_done); end
    vectors++; if (rx_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", rx_err); end
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", rx_idle); end
    reset = 1'b1;
    settle(10);
  endtask

  // Full frame of byte b with correct odd parity; expects exactly one rx_done.
  task automatic test_good_frame(input logic [7:0] b, input logic par, input string name);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    got_q.delete();
    send_bits(mk_frame(b, par, 1'b1), 11);
    settle(40);
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt - d0); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL %s_err: got %0d pulses want 0", name, err_cnt - e0); end
    vectors++; if (rx_data !== b) begin miscompares++; $display("FAIL %s_data: got %h want %h", name, rx_data, b); end
    vectors++; if (got_q.size() != 1 || got_q[0] !== b) begin miscompares++; $display("FAIL %s_capture: got %0d bytes want 1 of %h", name, got_q.size(), b); end
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL %s_idle: got %b want 1", name, rx_idle); end
  endtask

  // Bad frame (parity or stop); expects one rx_err, no rx_done, data held.
  task automatic test_bad_frame(input logic [7:0] b, input logic par, input logic stop,
                                input logic [7:0] held, input string name);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_bits(mk_frame(b, par, stop), 11);
    settle(40);
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL %s_err: got %0d pulses want 1", name, err_cnt - e0); end
    vectors++; if (done_cnt - d0 != 0) begin miscompares++; $display("FAIL %s_done: got %0d pulses want 0", name, done_cnt - d0); end
    vectors++; if (rx_data !== held) begin miscompares++; $display("FAIL %s_data: got %h want %h", name, rx_data, held); end
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL %s_idle: got %b want 1", name, rx_idle); end
  endtask

  task automatic test_glitch();
    ps2c = 1'b0;
    repeat (3) @(posedge clk);
    ps2c = 1'b1;
    settle(30);
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL glitch_idle: got %b want 1", rx_idle); end
    test_good_frame(8'h5A, 1'b1, "glitch_5a");
  endtask

  task automatic test_timeout(input logic [7:0] held);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h00, 1'b1, 1'b1), 5);
    settle(2 * TMO);
`ifdef PS2_RX_TIMEOUT_EN
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL tmo_stall_err: got %0d want 1", err_cnt - e0); end
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL tmo_stall_idle: got %b want 1", rx_idle); end
    test_good_frame(8'h29, 1'b0, "tmo_29");
`else
    vectors++; if (rx_idle !== 1'b0) begin miscompares++; $display("FAIL tmo_stall_busy: got idle %b want 0", rx_idle); end
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11);
    settle(40);
    // Misaligned frame hits a 0 in the stop slot, then restarts and stalls again.
    vectors++; if (done_cnt - d0 != 0) begin miscompares++; $display("FAIL tmo_spurious_done: got %0d want 0", done_cnt - d0); end
    vectors++; if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL tmo_err: got %0d want 1", err_cnt - e0); end
    vectors++; if (rx_data !== held) begin miscompares++; $display("FAIL tmo_data: got %h want %h", rx_data, held); end
    vectors++; if (rx_idle !== 1'b0) begin miscompares++; $display("FAIL tmo_restall: got idle %b want 0", rx_idle); end
    rx_en = 1'b0;
    settle(3);
    rx_en = 1'b1;
    settle(3);
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL tmo_recover_idle: got %b want 1", rx_idle); end
`endif
  endtask

  task automatic test_abort(input logic [7:0] held);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h77, 1'b1, 1'b1), 5);
    settle(2);
    vectors++; if (rx_idle !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got idle %b want 0", rx_idle); end
    rx_en = 1'b0;
    settle(3);
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got %b want 1", rx_idle); end
    vectors++; if (rx_data !== held) begin miscompares++; $display("FAIL abort_data: got %h want %h", rx_data, held); end
    rx_en = 1'b1;
    settle(10);
    vectors++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin miscompares++; $display("FAIL abort_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    test_good_frame(8'h1C, 1'b0, "abort_1c");
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h3C, 1'b1, 1'b1), 7);
    reset = 1'b0;
    settle(3);
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    vectors++; if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle: got %b want 1", rx_idle); end
    reset = 1'b1;
    settle(10);
    vectors++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin miscompares++; $display("FAIL rstmid_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    test_good_frame(8'h1C, 1'b0, "rstmid_1c");
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    got_q.delete();
    send_bits(mk_frame(8'h12, 1'b1, 1'b1), 11);
    send_bits(mk_frame(8'h34, 1'b0, 1'b1), 11);
    settle(40);
    vectors++; if (done_cnt - d0 != 2) begin miscompares++; $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); end
    vectors++; if (err_cnt - e0 != 0) begin miscompares++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
    vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d bytes want 2", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 8'h12) begin miscompares++; $display("FAIL b2b_first: got %h want 12", got_q[0]); end
      vectors++; if (got_q[1] !== 8'h34) begin miscompares++; $display("FAIL b2b_second: got %h want 34", got_q[1]); end
    end
  endtask

  task automatic test_pulse_shape();
    vectors++; if (overlap_cnt != 0) begin miscompares++; $display("FAIL done_err_overlap: got %0d cycles want 0", overlap_cnt); end
    vectors++; if (wide_cnt != 0) begin miscompares++; $display("FAIL pulse_width: got %0d long pulses want 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame(8'h1C, 1'b0, "good_1c");
    test_bad_frame(8'hF0, 1'b0, 1'b1, 8'h1C, "parity_f0");
    test_bad_frame(8'hAA, 1'b1, 1'b0, 8'h1C, "stop_aa");
    test_glitch();
    test_timeout(8'h5A);
`ifdef PS2_RX_TIMEOUT_EN
    test_abort(8'h29);
`else
    test_abort(8'h5A);
`endif
    test_reset_mid();
    test_back_to_back();
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
